// File: rtl/regfile_wb_writer.sv
// Register-file write-back buffer: queues ALU/LSU results, drives one RF write per clock
// and flags read-after-write hazards. Define WB_FWD_EN to add the forwarding outputs.
module regfile_wb_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          res,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] chk_a1,
    input  logic [AW-1:0] chk_a2,
`ifdef WB_FWD_EN
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd2_data,
`endif
    output logic          hz1,
    output logic          hz2,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW-1:0]  lsu_slot;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  free;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]  rd_q   [DEPTH];
    logic [AW-1:0]  rd_d   [DEPTH];
    logic [DW-1:0]  data_q [DEPTH];
    logic [DW-1:0]  data_d [DEPTH];
    logic           rf_we_q, rf_we_d;
    logic [AW-1:0]  rf_a3_q, rf_a3_d;
    logic [DW-1:0]  rf_wd_q, rf_wd_d;
    logic           enq_alu, enq_lsu, deq;

    // Valid/ready: a source transfers when valid && ready at a rising edge. Readiness
    // looks only at the registered count, so the same-cycle pop never frees a slot early.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        alu_ready = (free >= CW'(1));
        lsu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !alu_valid);
        enq_alu   = alu_valid && alu_ready && (alu_rd != '0);
        enq_lsu   = lsu_valid && lsu_ready && (lsu_rd != '0);
        deq       = (count_q != '0);
    end

    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        vld_d    = vld_q;
        lsu_slot = enq_alu ? (tail_q + PW'(1)) : tail_q;
        if (deq) begin
            vld_d[head_q] = 1'b0;
        end
        // ALU is older than a same-cycle LSU result, so it takes the tail slot first.
        if (enq_alu) begin
            rd_d[tail_q]   = alu_rd;
            data_d[tail_q] = alu_data;
            vld_d[tail_q]  = 1'b1;
        end
        if (enq_lsu) begin
            rd_d[lsu_slot]   = lsu_rd;
            data_d[lsu_slot] = lsu_data;
            vld_d[lsu_slot]  = 1'b1;
        end
        tail_d  = tail_q + PW'(enq_alu) + PW'(enq_lsu);
        head_d  = head_q + PW'(deq);
        count_d = count_q + CW'(enq_alu) + CW'(enq_lsu) - CW'(deq);
    end

    always_comb begin
        rf_we_d = deq;
        rf_a3_d = rf_a3_q;
        rf_wd_d = rf_wd_q;
        if (deq) begin
            rf_a3_d = rd_q[head_q];
            rf_wd_d = data_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            rf_we_q <= 1'b0;
            rf_a3_q <= '0;
            rf_wd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            rf_we_q <= rf_we_d;
            rf_a3_q <= rf_a3_d;
            rf_wd_q <= rf_wd_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Hazards cover queued entries and the rf_* stage; x0 never hazards.
    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_q[i] == chk_a1)) hz1 = 1'b1;
            if (vld_q[i] && (rd_q[i] == chk_a2)) hz2 = 1'b1;
        end
        if (rf_we_q && (rf_a3_q == chk_a1)) hz1 = 1'b1;
        if (rf_we_q && (rf_a3_q == chk_a2)) hz2 = 1'b1;
        if (chk_a1 == '0) hz1 = 1'b0;
        if (chk_a2 == '0) hz2 = 1'b0;
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        fwd_idx   = head_q;
        fwd1_data = '0;
        fwd2_data = '0;
        if (rf_we_q && (rf_a3_q == chk_a1)) fwd1_data = rf_wd_q;
        if (rf_we_q && (rf_a3_q == chk_a2)) fwd2_data = rf_wd_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (vld_q[fwd_idx] && (rd_q[fwd_idx] == chk_a1)) fwd1_data = data_q[fwd_idx];
            if (vld_q[fwd_idx] && (rd_q[fwd_idx] == chk_a2)) fwd2_data = data_q[fwd_idx];
        end
        fwd1_hit = hz1;
        fwd2_hit = hz2;
    end
`endif

    assign rf_we = rf_we_q;
    assign rf_a3 = rf_a3_q;
    assign rf_wd = rf_wd_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0) && !rf_we_q;

endmodule
